// File: rtl/modexp_ctrl_if.sv
// Multiplier request bus between the modexp sequencer (master) and a
// modular multiplier (slave): one request in flight, start/done pulses.
interface modexp_ctrl_if #(
    parameter int nbits = 256
);
    logic             mul_start;
    logic [nbits-1:0] mul_x;
    logic [nbits-1:0] mul_y;
    logic [nbits-1:0] mul_n;
    logic             mul_done;
    logic [nbits-1:0] mul_out;

    modport master (
        output mul_start, mul_x, mul_y, mul_n,
        input  mul_done, mul_out
    );

    modport slave (
        input  mul_start, mul_x, mul_y, mul_n,
        output mul_done, mul_out
    );
endinterface

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer: out = a^e mod n, issuing one
// modular multiplication at a time to an external multiplier.
module modexp_ctrl #(
    parameter int nbits = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [nbits-1:0]  a,
    input  logic [nbits-1:0]  e,
    input  logic [nbits-1:0]  n,
    output logic              busy,
    output logic              done,
    output logic [nbits-1:0]  out,
    modexp_ctrl_if.master     mul
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL_REQ,
        MUL_WAIT,
        SQR_REQ,
        SQR_WAIT,
        FIN
    } state_t;

    localparam logic [nbits-1:0] ONE = {{(nbits-1){1'b0}}, 1'b1};

    state_t           state;
    logic [nbits-1:0] res;
    logic [nbits-1:0] base;
    logic [nbits-1:0] exp;

    // mul_n doubles as the latched modulus; it only changes on an accepted start.
    // NOTE: every register here, outputs included, is written with <= so all
    // state updates see the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            out           <= '0;
            res           <= '0;
            base          <= '0;
            exp           <= '0;
            mul.mul_start <= 1'b0;
            mul.mul_x     <= '0;
            mul.mul_y     <= '0;
            mul.mul_n     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        res       <= ONE;
                        base      <= a;
                        exp       <= e;
                        mul.mul_n <= n;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end

                CHECK: begin
                    if (exp == '0) begin
                        state <= FIN;
                    end else if (exp[0]) begin
                        mul.mul_x     <= res;
                        mul.mul_y     <= base;
                        mul.mul_start <= 1'b1;
                        state         <= MUL_REQ;
                    end else begin
                        mul.mul_x     <= base;
                        mul.mul_y     <= base;
                        mul.mul_start <= 1'b1;
                        state         <= SQR_REQ;
                    end
                end

                MUL_REQ: begin
                    mul.mul_start <= 1'b0;
                    state         <= MUL_WAIT;
                end

                MUL_WAIT: begin
                    if (mul.mul_done) begin
                        res <= mul.mul_out;
                        // Last set bit consumed: skip the useless trailing square.
                        if (exp[nbits-1:1] == '0) begin
                            exp   <= exp >> 1;
                            state <= FIN;
                        end else begin
                            mul.mul_x     <= base;
                            mul.mul_y     <= base;
                            mul.mul_start <= 1'b1;
                            state         <= SQR_REQ;
                        end
                    end
                end

                SQR_REQ: begin
                    mul.mul_start <= 1'b0;
                    state         <= SQR_WAIT;
                end

                SQR_WAIT: begin
                    if (mul.mul_done) begin
                        base  <= mul.mul_out;
                        exp   <= exp >> 1;
                        state <= CHECK;
                    end
                end

                FIN: begin
                    out   <= res;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: behavioural multiplier stub, a
// request/result model derived from the exponent bits, and directed vectors.
module tb_modexp_ctrl;

    localparam int NB = 256;
    typedef logic [NB-1:0]   word_t;
    typedef logic [2*NB-1:0] dword_t;
    typedef struct {
        word_t x;
        word_t y;
    } req_t;

    localparam word_t N256 = 256'hE07122F2_9C4D8A17_5B3E6F01_D2A4C8B7_1F6E3A95_8B0C7D24_E5F19A36_C4B273E1;
    localparam word_t A256 = 256'hC22CA5BF_3D8E1A74_96F0B25C_E71D4A83_5C9B2F06_A84E7D13_F26B9C5E_07D48CA1;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    word_t a, e, n;
    logic  busy, done;
    word_t out;

    modexp_ctrl_if #(.nbits(NB)) mul ();

    modexp_ctrl #(.nbits(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .e     (e),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .mul   (mul)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input word_t got, input word_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic word_t mulmod(input word_t x, input word_t y, input word_t m);
        dword_t p;
        p = dword_t'(x) * dword_t'(y);
        return word_t'(p % dword_t'(m));
    endfunction

    // Left-to-right exponentiation: an independent route to the same answer.
    function automatic word_t powmod(input word_t b, input word_t ex, input word_t m);
        word_t r;
        r = word_t'(1);
        for (int i = NB - 1; i >= 0; i--) begin
            r = mulmod(r, r, m);
            if (ex[i]) r = mulmod(r, b, m);
        end
        return r;
    endfunction

    // ---------------- multiplier stub: done 5 cycles after mul_start --------
    int    scnt = 0;
    word_t sx, sy, sn;

    always @(posedge clk) begin
        if (mul.mul_start === 1'b1) begin
            sx   <= mul.mul_x;
            sy   <= mul.mul_y;
            sn   <= mul.mul_n;
            scnt <= 4;
        end else if (scnt != 0) begin
            scnt <= scnt - 1;
        end
        mul.mul_done <= (scnt == 1) && (mul.mul_start !== 1'b1);
        mul.mul_out  <= (scnt == 1) ? mulmod(sx, sy, sn) : '0;
    end

    // ---------------- model state ----------------
    req_t  exp_q[$];
    word_t exp_out;
    word_t exp_n;
    bit    done_armed = 0;
    int    mul_cnt    = 0;
    int    done_cnt   = 0;
    int    cyc        = 0;
    int    start_cyc  = 0;
    int    done_cyc   = 0;
    bit    pending    = 0;
    req_t  held;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected request sequence: walk e from bit 0 up to its top set bit;
    // set bits multiply into the result, every bit below the top squares.
    task automatic plan_op(input word_t pa, input word_t pe, input word_t pn);
        word_t r, b;
        int    top;
        r   = word_t'(1);
        b   = pa;
        top = -1;
        exp_q.delete();
        for (int i = 0; i < NB; i++) if (pe[i]) top = i;
        for (int i = 0; i <= top; i++) begin
            if (pe[i]) begin
                exp_q.push_back('{x: r, y: b});
                r = mulmod(r, b, pn);
            end
            if (i < top) begin
                exp_q.push_back('{x: b, y: b});
                b = mulmod(b, b, pn);
            end
        end
        exp_out    = powmod(pa, pe, pn);
        exp_n      = pn;
        done_armed = 1;
        mul_cnt    = 0;
        done_cnt   = 0;
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
            end else begin
                if (start && !busy) start_cyc = cyc;
                if (mul.mul_start) begin
                    mul_cnt++;
                    check("mul_start_busy", word_t'(busy), word_t'(1));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mul_start_extra: request %0d not expected", mul_cnt);
                    end else begin
                        held = exp_q.pop_front();
                        check("mul_x", mul.mul_x, held.x);
                        check("mul_y", mul.mul_y, held.y);
                        check("mul_n", mul.mul_n, exp_n);
                        pending = 1;
                    end
                end else if (pending) begin
                    check("mul_x_hold", mul.mul_x, held.x);
                    check("mul_y_hold", mul.mul_y, held.y);
                    check("mul_n_hold", mul.mul_n, exp_n);
                    if (mul.mul_done) pending = 0;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_busy", word_t'(busy), word_t'(1));
                    if (done_armed) begin
                        check("out", out, exp_out);
                        done_armed = 0;
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got done=1, expected 0");
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic pulse_start(input word_t pa, input word_t pe, input word_t pn);
        @(posedge clk);
        #1;
        a     = pa;
        e     = pe;
        n     = pn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    // Runs after wait_done: one cycle past the done pulse.
    task automatic finish_op(input string name, input word_t want_out, input int want_muls);
        @(negedge clk);
        check({name, "_busy_after"}, word_t'(busy), word_t'(0));
        check({name, "_done_pulse"}, word_t'(done), word_t'(0));
        check({name, "_out"}, out, want_out);
        check({name, "_mul_count"}, word_t'(mul_cnt), word_t'(want_muls));
        check({name, "_done_count"}, word_t'(done_cnt), word_t'(1));
        check({name, "_reqs_left"}, word_t'(exp_q.size()), word_t'(0));
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_busy"}, word_t'(busy), word_t'(0));
        check({name, "_done"}, word_t'(done), word_t'(0));
        check({name, "_mul_start"}, word_t'(mul.mul_start), word_t'(0));
        check({name, "_out"}, out, word_t'(0));
        check({name, "_mul_x"}, mul.mul_x, word_t'(0));
        check({name, "_mul_y"}, mul.mul_y, word_t'(0));
        check({name, "_mul_n"}, mul.mul_n, word_t'(0));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        word_t gold;
        bit    got_sqr;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        e     = '0;
        n     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;

        check("model_3_5_7", powmod(word_t'(3), word_t'(5), word_t'(7)), word_t'(5));
        check("model_2_10_1000", powmod(word_t'(2), word_t'(10), word_t'(1000)), word_t'(24));

        // 3^5 mod 7: MUL(1,3) SQR(3,3) SQR(2,2) MUL(3,4)
        plan_op(word_t'(3), word_t'(5), word_t'(7));
        check("plan_3_5_7_len", word_t'(exp_q.size()), word_t'(4));
        pulse_start(word_t'(3), word_t'(5), word_t'(7));
        wait_done("pow_3_5_7", 200);
        finish_op("pow_3_5_7", word_t'(5), 4);

        // e = 0: no requests, result 1, done three cycles after start
        plan_op(word_t'(16'h1234), word_t'(0), N256);
        pulse_start(word_t'(16'h1234), word_t'(0), N256);
        wait_done("e0", 50);
        check("e0_latency", word_t'(done_cyc - start_cyc), word_t'(3));
        finish_op("e0", word_t'(1), 0);

        // e = 1: single MUL(1, a)
        plan_op(A256, word_t'(1), N256);
        pulse_start(A256, word_t'(1), N256);
        wait_done("e1", 100);
        finish_op("e1", A256, 1);

        // e = 65537: sixteen squarings then one multiply
        gold = A256;
        for (int i = 0; i < 16; i++) gold = mulmod(gold, gold, N256);
        gold = mulmod(gold, A256, N256);
        plan_op(A256, word_t'(32'h10001), N256);
        pulse_start(A256, word_t'(32'h10001), N256);
        wait_done("e65537", 1000);
        finish_op("e65537", gold, 18);

        // Reset during SQR_WAIT; the stub's late mul_done must go unnoticed
        plan_op(word_t'(3), word_t'(5), word_t'(7));
        pulse_start(word_t'(3), word_t'(5), word_t'(7));
        got_sqr = 0;
        for (int i = 0; i < 100 && !got_sqr; i++) begin
            @(negedge clk);
            if (mul_cnt >= 2) got_sqr = 1;
        end
        check("rst_reached_sqr", word_t'(got_sqr), word_t'(1));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        done_armed = 0;
        done_cnt   = 0;
        @(posedge clk);
        #1;
        check_idle_zero("midrst");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_done", word_t'(done_cnt), word_t'(0));
        check("midrst_idle", word_t'(busy), word_t'(0));

        plan_op(word_t'(2), word_t'(10), word_t'(1000));
        pulse_start(word_t'(2), word_t'(10), word_t'(1000));
        wait_done("pow_2_10_1000", 200);
        finish_op("pow_2_10_1000", word_t'(24), 5);

        // A second start while busy must be ignored entirely
        plan_op(word_t'(3), word_t'(5), word_t'(7));
        pulse_start(word_t'(3), word_t'(5), word_t'(7));
        repeat (3) @(posedge clk);
        pulse_start(word_t'(2), word_t'(10), word_t'(1000));
        wait_done("busy_ignore", 200);
        finish_op("busy_ignore", word_t'(5), 4);
        repeat (20) @(negedge clk);
        check("busy_ignore_single_done", word_t'(done_cnt), word_t'(1));
        check("busy_ignore_no_extra_mul", word_t'(mul_cnt), word_t'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencing controller that drives the modular multiplier's start/done/x/y/n/out interface from the initiator side.
- Computes out = a^e mod n using right-to-left square-and-multiply.
- Issues one modular multiplication request at a time to an external multiplier instance, and is the block the RSA datapath instantiates above that multiplier.

Parameters:
- nbits, 256, width of operands, modulus, exponent and result.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request pulse; accepted only in IDLE.
- a  input  nbits  base; caller guarantees a < n; sampled on accepted start.
- e  input  nbits  exponent; sampled on accepted start.
- n  input  nbits  modulus; caller guarantees n > 1; sampled on accepted start.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse when out is valid.
- out  output  nbits  result; valid from the done cycle, held until the next accepted start.
- mul_start  output  1  one-cycle request pulse to the multiplier.
- mul_x  output  nbits  multiplier operand x; stable from mul_start until mul_done.
- mul_y  output  nbits  multiplier operand y; same stability rule as mul_x.
- mul_n  output  nbits  multiplier modulus; equals the latched n throughout an operation.
- mul_done  input  1  multiplier completion pulse.
- mul_out  input  nbits  multiplier result, (mul_x*mul_y) mod mul_n; sampled when mul_done=1.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, mul_start=0; out, mul_x, mul_y, mul_n, and the internal res/base/exp registers all 0.
- Reset mid-operation:
  - Return to IDLE with the reset values above.
  - A later mul_done from the abandoned request is ignored.
- Internal registers: res, base, exp (all nbits).
- IDLE:
  - start=1 → latch res=1, base=a, exp=e, n_reg=n.
  - Assert busy next cycle; go to CHECK.
  - start=0 → stay in IDLE; done=0.
- CHECK (one cycle):
  - exp==0 → FIN.
  - Else if exp[0]=1 → MUL_REQ.
  - Else → SQR_REQ.
- MUL_REQ (one cycle):
  - Drive mul_x=res, mul_y=base, mul_n=n_reg, mul_start=1.
  - Go to MUL_WAIT.
- MUL_WAIT:
  - Hold mul_x/mul_y/mul_n; mul_start=0.
  - On mul_done=1: res<=mul_out.
  - Then if (exp>>1)==0 → shift exp, go to FIN (no trailing square).
  - Else → SQR_REQ.
- SQR_REQ (one cycle):
  - mul_x=base, mul_y=base, mul_start=1.
  - Go to SQR_WAIT.
- SQR_WAIT:
  - On mul_done=1: base<=mul_out, exp<=exp>>1.
  - Go to CHECK.
- FIN (one cycle):
  - out<=res, done=1 in this cycle.
  - Go to IDLE.
  - busy deasserts the following cycle.
- Handshake rules:
  - start while busy: ignored, no effect on registers.
  - mul_done outside the WAIT states: ignored.
  - mul_done in the same cycle as mul_start: not possible; mul_done is sampled only in WAIT states.
  - Exactly one multiplier request outstanding at any time.
- Request count: popcount(e) MUL requests plus (index of the highest set bit of e) SQR requests.
- e=0: no multiplier requests; out=1; done exactly 3 cycles after the start cycle (IDLE→CHECK→FIN, done in FIN).
- Width rules:
  - All values are nbits, unsigned.
  - No pre-reduction of a; a ≥ n gives an undefined result.
  - Constant 1 is zero-extended to nbits.
- start and done in the same cycle: done belongs to the prior operation; FIN does not accept start; start is accepted only in IDLE.

Test Plan:
- Bench uses a behavioural multiplier stub: result=(x*y) mod n, done 5 cycles after mul_start.
- a=3, e=5, n=7 → out=5; exactly 4 mul_start pulses in order MUL,SQR,SQR,MUL; busy high throughout; single done pulse.
- a=0x1234, e=0, n=0xE07122F2...73E1 (256-bit) → out=1, zero mul_start pulses, done 3 cycles after start.
- a=0xc22ca5bf...8ca1, e=1, n=0xE07122F2...73E1 → out=a, exactly 1 mul_start with mul_x=1, mul_y=a.
- a=0xc22ca5bf...8ca1, e=0x10001, n=0xE07122F2...73E1 → out equals the golden model pow(a,65537,n); exactly 18 mul_start pulses.
- Mid-operation: assert rst for 1 cycle during SQR_WAIT → all outputs 0 next cycle; stub's late mul_done produces no done. Then a=2, e=10, n=1000 → out=24.
- Pulse start again while busy with different a,e,n → ignored; result matches the first request; only one done.
